// File: rtl/better_neighbor_scan_if.sv
// ----------------------------------------------------------------------------
// better_neighbor_scan_if
// Bundles the scan control, neighbor-cost memory read port, better-neighbor
// list write port and status of better_neighbor_scan.
//   master : the environment (issues start, returns memory read data)
//   slave  : the scanner itself
// Signals:
//   start, current_cost, num_neighbors        -> scan request
//   nbr_rd_en, nbr_rd_addr / nbr_cost         -> neighbor-cost memory read
//   list_wr_en, list_wr_addr, list_wr_data    -> better-neighbor list write
//   better_neighbor_count, busy, done         -> status
// ----------------------------------------------------------------------------
interface better_neighbor_scan_if #(
  parameter int ADDR_W = 16,
  parameter int COST_W = 16
);
  logic              start;
  logic [COST_W-1:0] current_cost;
  logic [ADDR_W-1:0] num_neighbors;
  logic              nbr_rd_en;
  logic [ADDR_W-1:0] nbr_rd_addr;
  logic [COST_W-1:0] nbr_cost;
  logic              list_wr_en;
  logic [ADDR_W-1:0] list_wr_addr;
  logic [ADDR_W-1:0] list_wr_data;
  logic [ADDR_W-1:0] better_neighbor_count;
  logic              busy;
  logic              done;

  modport master (
    output start, current_cost, num_neighbors, nbr_cost,
    input  nbr_rd_en, nbr_rd_addr, list_wr_en, list_wr_addr, list_wr_data,
           better_neighbor_count, busy, done
  );

  modport slave (
    input  start, current_cost, num_neighbors, nbr_cost,
    output nbr_rd_en, nbr_rd_addr, list_wr_en, list_wr_addr, list_wr_data,
           better_neighbor_count, busy, done
  );
endinterface

// File: rtl/better_neighbor_scan.sv
// ----------------------------------------------------------------------------
// better_neighbor_scan
// Reads N neighbor costs from an external memory (one-cycle read latency),
// and writes the index of every neighbor strictly cheaper than the captured
// current cost into a dense list. Reports the number found and pulses done.
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous, active-high reset
//   bus   : better_neighbor_scan_if.slave (control, memory ports, status)
// Timing (start sampled at edge E0, cycle k = period after edge E(k-1)):
//   read of index k in cycle k+1, list write for index k in cycle k+3,
//   done in cycle N+3 (cycle 1 when N = 0). All outputs are registered.
// ----------------------------------------------------------------------------
module better_neighbor_scan #(
  parameter int ADDR_W = 16,
  parameter int COST_W = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  better_neighbor_scan_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_next_state;

  logic [COST_W-1:0] r_cost;       // current_cost captured at start
  logic [ADDR_W-1:0] r_last_idx;   // N-1, captured at start
  logic              r_rd_en;
  logic [ADDR_W-1:0] r_rd_addr;
  logic              r_cmp_vld;    // nbr_cost carries valid read data this cycle
  logic [ADDR_W-1:0] r_cmp_idx;    // index that nbr_cost belongs to
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [ADDR_W-1:0] r_wr_data;
  logic [ADDR_W-1:0] r_count;
  logic              r_busy;
  logic              r_done;

  logic              w_accept;
  logic              w_better;

  assign w_accept = (r_state == S_IDLE) && bus.start;
  // Strict unsigned compare: a tie with the current cost is not an improvement.
  assign w_better = r_cmp_vld && (bus.nbr_cost < r_cost);

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_next_state = (bus.num_neighbors == '0) ? S_DONE : S_SCAN;
        end
      end
      S_SCAN: begin
        if (r_rd_addr == r_last_idx) begin
          w_next_state = S_DRAIN;
        end
      end
      // Leave once the final read's compare has been seen; its list write
      // (if any) occupies the cycle after that, overlapping the exit edge.
      S_DRAIN: begin
        if (!r_cmp_vld) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // NOTE: every register here is a real flop with a defined reset value;
  // there is no storage array, so nothing is left uninitialised after reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cost     <= '0;
      r_last_idx <= '0;
      r_rd_en    <= 1'b0;
      r_rd_addr  <= '0;
      r_cmp_vld  <= 1'b0;
      r_cmp_idx  <= '0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_count    <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_rd_en   <= (w_next_state == S_SCAN);
      r_busy    <= (w_next_state == S_SCAN) || (w_next_state == S_DRAIN);
      r_done    <= (w_next_state == S_DONE);

      if (w_accept) begin
        r_rd_addr <= '0;
      end else if ((r_state == S_SCAN) && (w_next_state == S_SCAN)) begin
        r_rd_addr <= r_rd_addr + ADDR_W'(1);
      end

      // Read data returns one cycle after the strobe; track which index it is.
      r_cmp_vld <= r_rd_en;
      r_cmp_idx <= r_rd_addr;

      r_wr_en <= w_better;
      if (w_better) begin
        r_wr_addr <= r_count;
        r_wr_data <= r_cmp_idx;
        r_count   <= r_count + ADDR_W'(1);
      end

      // Compares never run in IDLE, so clearing the count cannot collide
      // with an increment.
      if (w_accept) begin
        r_cost     <= bus.current_cost;
        r_last_idx <= bus.num_neighbors - ADDR_W'(1);
        r_count    <= '0;
      end
    end
  end

  assign bus.nbr_rd_en             = r_rd_en;
  assign bus.nbr_rd_addr           = r_rd_addr;
  assign bus.list_wr_en            = r_wr_en;
  assign bus.list_wr_addr          = r_wr_addr;
  assign bus.list_wr_data          = r_wr_data;
  assign bus.better_neighbor_count = r_count;
  assign bus.busy                  = r_busy;
  assign bus.done                  = r_done;

endmodule

// File: tb/tb_better_neighbor_scan.sv
// ----------------------------------------------------------------------------
// tb_better_neighbor_scan
// Directed bench for better_neighbor_scan. A 16-entry neighbor-cost memory
// model answers reads one cycle after nbr_rd_en. Each scan is checked cycle
// by cycle against hand-derived expectations: read strobes in cycles 1..N,
// list writes in cycle k+3 for each better index k (given as a bit mask),
// done in cycle N+3 (or 1 for N = 0), and the final count.
// ----------------------------------------------------------------------------
module tb_better_neighbor_scan;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  better_neighbor_scan_if #(.ADDR_W(16), .COST_W(16)) bus_if ();

  better_neighbor_scan #(.ADDR_W(16), .COST_W(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  logic [15:0] mem [16];
  int n_tests = 0;
  int n_fail  = 0;

  // Memory model; drives 0 when not read so mistimed sampling looks "better".
  always @(posedge clock) begin
    if (bus_if.nbr_rd_en) bus_if.nbr_cost <= mem[bus_if.nbr_rd_addr[3:0]];
    else                  bus_if.nbr_cost <= 16'h0000;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check_idle_outputs(input string name);
    n_tests++;
    if (bus_if.nbr_rd_en !== 1'b0) begin n_fail++; $display("FAIL %s rd_en: got %b exp 0", name, bus_if.nbr_rd_en); end
    n_tests++;
    if (bus_if.list_wr_en !== 1'b0) begin n_fail++; $display("FAIL %s wr_en: got %b exp 0", name, bus_if.list_wr_en); end
    n_tests++;
    if (bus_if.done !== 1'b0) begin n_fail++; $display("FAIL %s done: got %b exp 0", name, bus_if.done); end
    n_tests++;
    if (bus_if.busy !== 1'b0) begin n_fail++; $display("FAIL %s busy: got %b exp 0", name, bus_if.busy); end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus_if.start = 1'b0;
    bus_if.current_cost = '0;
    bus_if.num_neighbors = '0;
    repeat (2) @(negedge clock);
    check_idle_outputs("reset");
    n_tests++;
    if (bus_if.better_neighbor_count !== 16'd0) begin
      n_fail++; $display("FAIL reset count: got %0d exp 0", bus_if.better_neighbor_count);
    end
    n_tests++;
    if (bus_if.list_wr_addr !== 16'd0 || bus_if.list_wr_data !== 16'd0 || bus_if.nbr_rd_addr !== 16'd0) begin
      n_fail++; $display("FAIL reset addr/data: got %h/%h/%h exp 0/0/0",
                         bus_if.list_wr_addr, bus_if.list_wr_data, bus_if.nbr_rd_addr);
    end
    reset = 1'b0;
  endtask

  // mask bit k set <=> neighbor k is strictly cheaper than cc (hand-derived).
  // poke_start raises start mid-scan and in the DONE cycle; both must be ignored.
  task automatic run_scan(input string name, input int n, input logic [15:0] cc,
                          input logic [15:0] mask, input bit poke_start);
    int done_cyc;
    int slot;
    int k;
    bit exp_wr;
    logic [15:0] exp_cnt;
    done_cyc = (n == 0) ? 1 : n + 3;
    exp_cnt  = 16'($countones(mask));
    slot     = 0;
    @(negedge clock);
    bus_if.current_cost  = cc;
    bus_if.num_neighbors = 16'(n);
    bus_if.start         = 1'b1;
    @(negedge clock);
    // Changes after capture must not affect the running scan.
    bus_if.start         = 1'b0;
    bus_if.current_cost  = ~cc;
    bus_if.num_neighbors = 16'(n + 5);
    for (int c = 1; c <= done_cyc; c++) begin
      n_tests++;
      if (bus_if.nbr_rd_en !== (c <= n)) begin
        n_fail++; $display("FAIL %s rd_en cycle %0d: got %b exp %b", name, c, bus_if.nbr_rd_en, (c <= n));
      end
      if (c <= n) begin
        n_tests++;
        if (bus_if.nbr_rd_addr !== 16'(c - 1)) begin
          n_fail++; $display("FAIL %s rd_addr cycle %0d: got %0d exp %0d", name, c, bus_if.nbr_rd_addr, c - 1);
        end
      end
      k = c - 3;
      exp_wr = 1'b0;
      if (k >= 0 && k < n) exp_wr = mask[k];
      n_tests++;
      if (bus_if.list_wr_en !== exp_wr) begin
        n_fail++; $display("FAIL %s wr_en cycle %0d: got %b exp %b", name, c, bus_if.list_wr_en, exp_wr);
      end
      if (exp_wr) begin
        n_tests++;
        if (bus_if.list_wr_addr !== 16'(slot) || bus_if.list_wr_data !== 16'(k)) begin
          n_fail++; $display("FAIL %s wr slot/data cycle %0d: got %0d/%0d exp %0d/%0d",
                             name, c, bus_if.list_wr_addr, bus_if.list_wr_data, slot, k);
        end
        slot++;
      end
      n_tests++;
      if (bus_if.done !== (c == done_cyc)) begin
        n_fail++; $display("FAIL %s done cycle %0d: got %b exp %b", name, c, bus_if.done, (c == done_cyc));
      end
      n_tests++;
      if (bus_if.busy !== (c < done_cyc)) begin
        n_fail++; $display("FAIL %s busy cycle %0d: got %b exp %b", name, c, bus_if.busy, (c < done_cyc));
      end
      if (c == done_cyc) begin
        n_tests++;
        if (bus_if.better_neighbor_count !== exp_cnt) begin
          n_fail++; $display("FAIL %s count at done: got %0d exp %0d", name, bus_if.better_neighbor_count, exp_cnt);
        end
      end
      bus_if.start = poke_start && (c == 2 || c == done_cyc);
      @(negedge clock);
    end
    bus_if.start = 1'b0;
    check_idle_outputs({name, " after done"});
    n_tests++;
    if (bus_if.better_neighbor_count !== exp_cnt) begin
      n_fail++; $display("FAIL %s count held: got %0d exp %0d", name, bus_if.better_neighbor_count, exp_cnt);
    end
  endtask

  task automatic load_req031();
    mem[0] = 16'd10; mem[1] = 16'd3; mem[2] = 16'd7; mem[3] = 16'd3;
  endtask

  task automatic test_reset_mid_scan();
    load_req031();
    @(negedge clock);
    bus_if.current_cost  = 16'd7;
    bus_if.num_neighbors = 16'd4;
    bus_if.start         = 1'b1;
    @(negedge clock);             // cycle 1
    bus_if.start = 1'b0;
    repeat (2) @(negedge clock);  // cycle 3
    n_tests++;
    if (bus_if.nbr_rd_en !== 1'b1 || bus_if.busy !== 1'b1) begin
      n_fail++; $display("FAIL mid_reset pre rd_en/busy: got %b/%b exp 1/1", bus_if.nbr_rd_en, bus_if.busy);
    end
    reset = 1'b1;
    #1;
    check_idle_outputs("mid_reset async");
    n_tests++;
    if (bus_if.better_neighbor_count !== 16'd0) begin
      n_fail++; $display("FAIL mid_reset count: got %0d exp 0", bus_if.better_neighbor_count);
    end
    @(negedge clock);
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      check_idle_outputs("mid_reset quiet");
    end
  endtask

  initial begin
    test_reset();

    // Mixed costs: indices 1 and 3 (cost 3) beat 7; tie at index 2 does not.
    load_req031();
    run_scan("req031", 4, 16'd7, 16'b1010, 1'b0);

    // N = 0: done directly after start.
    run_scan("n_zero", 0, 16'd7, 16'b0, 1'b0);

    // All ties: nothing is better.
    for (int i = 0; i < 3; i++) mem[i] = 16'd7;
    run_scan("all_ties", 3, 16'd7, 16'b0, 1'b0);

    // Everything better, back-to-back writes into slots 0..4.
    for (int i = 0; i < 5; i++) mem[i] = 16'd0;
    run_scan("all_better", 5, 16'd1, 16'b11111, 1'b0);

    // Unsigned compare at the top of the range.
    mem[0] = 16'hFFFF; mem[1] = 16'hFFFE; mem[2] = 16'h8000;
    run_scan("unsigned_top", 3, 16'hFFFF, 16'b110, 1'b0);

    // Extra starts mid-scan and in DONE are ignored; next start is accepted.
    load_req031();
    run_scan("start_ignored", 4, 16'd7, 16'b1010, 1'b1);
    run_scan("back_to_back", 4, 16'd4, 16'b1010, 1'b0);

    // Reset mid-scan aborts; a fresh start reproduces the reference scan.
    test_reset_mid_scan();
    run_scan("after_reset", 4, 16'd7, 16'b1010, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
